// File: rtl/accum_output_buffer.sv
// Multi-channel CNN output buffer: per-channel banks with overwrite or saturating
// accumulate writes, NRD registered read ports, and a clear / drain engine.
module accum_output_buffer #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned CH     = 4,
    parameter  int unsigned DEPTH  = 32,
    parameter  int unsigned NRD    = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic [CH-1:0]                          wr_en,
    input  logic                                   acc_mode,
    input  logic [CH-1:0][ADDR_W-1:0]              wr_addr,
    input  logic [CH-1:0][DATA_W-1:0]              wr_data,
    input  logic [NRD-1:0][CH-1:0][ADDR_W-1:0]     rd_addr,
    output logic [NRD-1:0][CH-1:0][DATA_W-1:0]     rd_data,
    input  logic                                   clr_start,
    input  logic                                   drain_start,
    output logic                                   busy,
    output logic                                   drain_valid,
    input  logic                                   drain_ready,
    output logic [CH-1:0][DATA_W-1:0]              drain_data,
    output logic [ADDR_W-1:0]                      drain_addr,
    output logic                                   drain_last,
    output logic                                   done
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                          state_q;
    logic [ADDR_W-1:0]               k_q;
    logic [ADDR_W-1:0]               k_d;
    logic                            k_last;
    logic                            busy_q;
    logic                            done_q;
    logic                            dvalid_q;
    logic                            dlast_q;
    logic [ADDR_W-1:0]               daddr_q;
    logic [CH-1:0][DATA_W-1:0]       ddata_q;
    logic [NRD-1:0][CH-1:0][DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0]               mem_q [CH][DEPTH];

    logic                            wr_ok;
    logic                            clr_ok;
    logic [CH-1:0][DATA_W-1:0]       wr_old_c;
    logic [CH-1:0][DATA_W:0]         wr_sum_c;
    logic [CH-1:0][DATA_W-1:0]       wr_val_c;
    logic [ADDR_W-1:0]               drain_ptr_c;
    logic [CH-1:0][DATA_W-1:0]       drain_row_c;

    assign k_d    = k_q + ADDR_W'(1);
    assign k_last = (k_q == K_LAST);
    assign wr_ok  = nrst && (state_q == ST_IDLE);
    assign clr_ok = nrst && (state_q == ST_CLEAR);

    // Write value: overwrite, or DATA_W+1-bit sum clamped to the signed range.
    always_comb begin
        wr_old_c = '0;
        wr_sum_c = '0;
        wr_val_c = '0;
        for (int c = 0; c < int'(CH); c++) begin
            wr_old_c[c] = mem_q[c][wr_addr[c]];
            wr_sum_c[c] = {wr_old_c[c][DATA_W-1], wr_old_c[c]}
                        + {wr_data[c][DATA_W-1], wr_data[c]};
            if (!acc_mode) begin
                wr_val_c[c] = wr_data[c];
            end else if (wr_sum_c[c][DATA_W] != wr_sum_c[c][DATA_W-1]) begin
                wr_val_c[c] = wr_sum_c[c][DATA_W] ? SAT_MIN : SAT_MAX;
            end else begin
                wr_val_c[c] = wr_sum_c[c][DATA_W-1:0];
            end
        end
    end

    // Row fetched into the drain register: entry 0 on start, k+1 on each accepted beat.
    always_comb begin
        drain_ptr_c = (state_q == ST_DRAIN) ? k_d : '0;
        drain_row_c = '0;
        for (int c = 0; c < int'(CH); c++) begin
            drain_row_c[c] = mem_q[c][drain_ptr_c];
        end
    end

    // Bank storage; contents survive reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(CH); c++) begin
            if (clr_ok) begin
                mem_q[c][k_q] <= '0;
            end else if (wr_ok && wr_en[c]) begin
                mem_q[c][wr_addr[c]] <= wr_val_c[c];
            end
        end
    end

    // Read ports: always enabled, old data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdata_q <= '0;
        end else begin
            for (int p = 0; p < int'(NRD); p++) begin
                for (int c = 0; c < int'(CH); c++) begin
                    rdata_q[p][c] <= mem_q[c][rd_addr[p][c]];
                end
            end
        end
    end

    // Control FSM with registered drain/status outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            daddr_q  <= '0;
            ddata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_q <= ST_CLEAR;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end else if (drain_start) begin
                        state_q  <= ST_DRAIN;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        dvalid_q <= 1'b1;
                        daddr_q  <= '0;
                        dlast_q  <= 1'b0;
                        ddata_q  <= drain_row_c;
                    end
                end
                ST_CLEAR: begin
                    if (k_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_d;
                    end
                end
                ST_DRAIN: begin
                    if (dvalid_q && drain_ready) begin
                        if (k_last) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            dvalid_q <= 1'b0;
                            dlast_q  <= 1'b0;
                        end else begin
                            k_q     <= k_d;
                            daddr_q <= k_d;
                            dlast_q <= (k_d == K_LAST);
                            ddata_q <= drain_row_c;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_data     = rdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign drain_valid = dvalid_q;
    assign drain_last  = dlast_q;
    assign drain_addr  = daddr_q;
    assign drain_data  = ddata_q;

endmodule

// File: tb/tb_accum_output_buffer.sv
// Directed + randomized bench for accum_output_buffer against an array-based
// model of bank contents with integer saturating arithmetic.
module tb_accum_output_buffer;

    localparam int DATA_W = 8;
    localparam int CH     = 4;
    localparam int DEPTH  = 32;
    localparam int NRD    = 4;
    localparam int ADDR_W = 5;
    localparam int SMAX   = 127;
    localparam int SMIN   = -128;

    logic                                   clk = 1'b0;
    logic                                   nrst;
    logic [CH-1:0]                          wr_en;
    logic                                   acc_mode;
    logic [CH-1:0][ADDR_W-1:0]              wr_addr;
    logic [CH-1:0][DATA_W-1:0]              wr_data;
    logic [NRD-1:0][CH-1:0][ADDR_W-1:0]     rd_addr;
    logic [NRD-1:0][CH-1:0][DATA_W-1:0]     rd_data;
    logic                                   clr_start;
    logic                                   drain_start;
    logic                                   busy;
    logic                                   drain_valid;
    logic                                   drain_ready;
    logic [CH-1:0][DATA_W-1:0]              drain_data;
    logic [ADDR_W-1:0]                      drain_addr;
    logic                                   drain_last;
    logic                                   done;

    int model [CH][DEPTH];
    int n_chk  = 0;
    int n_fail = 0;

    accum_output_buffer dut (
        .clk         (clk),
        .nrst        (nrst),
        .wr_en       (wr_en),
        .acc_mode    (acc_mode),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .clr_start   (clr_start),
        .drain_start (drain_start),
        .busy        (busy),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_data  (drain_data),
        .drain_addr  (drain_addr),
        .drain_last  (drain_last),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic int sx(input logic [DATA_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [NRD-1:0][CH-1:0][DATA_W-1:0] exp_rd();
        logic [NRD-1:0][CH-1:0][DATA_W-1:0] e;
        for (int p = 0; p < NRD; p++)
            for (int c = 0; c < CH; c++)
                e[p][c] = DATA_W'(model[c][rd_addr[p][c]]);
        return e;
    endfunction

    function automatic logic [CH-1:0][DATA_W-1:0] exp_row(input int k);
        logic [CH-1:0][DATA_W-1:0] e;
        for (int c = 0; c < CH; c++) e[c] = DATA_W'(model[c][k % DEPTH]);
        return e;
    endfunction

    // One IDLE cycle: expected read data is taken before the model applies writes.
    task automatic idle_step(input string tag);
        logic [NRD-1:0][CH-1:0][DATA_W-1:0] e;
        e = exp_rd();
        for (int c = 0; c < CH; c++)
            if (wr_en[c])
                model[c][wr_addr[c]] = acc_mode ? sat(model[c][wr_addr[c]] + sx(wr_data[c]))
                                                : sx(wr_data[c]);
        tick();
        chk(tag, rd_data, e);
    endtask

    task automatic sweep(input string tag);
        wr_en = '0;
        for (int a = 0; a < DEPTH; a++) begin
            for (int p = 0; p < NRD; p++)
                for (int c = 0; c < CH; c++)
                    rd_addr[p][c] = ADDR_W'(a + 3 * p + c);
            idle_step(tag);
        end
    endtask

    task automatic do_clear(input string tag);
        int cyc;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 128'(cyc), 128'(DEPTH));
        chk({tag, "_done"}, 128'(done), 128'(1));
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < DEPTH; k++) model[c][k] = 0;
        tick();
        chk({tag, "_done_drop"}, 128'(done), 128'(0));
        chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    endtask

    // Full drain; mode 0 = ready pattern 1,0,0 repeating, mode 1 = always ready.
    // Random writes are presented throughout and must be dropped.
    task automatic run_drain(input int mode, input string tag);
        int beat;
        int cyc;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        beat = 0;
        cyc  = 0;
        while (drain_valid && cyc < 400) begin
            drain_ready = (mode == 1) ? 1'b1 : (cyc % 3 == 0);
            wr_en    = CH'($urandom);
            acc_mode = 1'($urandom);
            wr_addr  = (CH*ADDR_W)'($urandom);
            wr_data  = (CH*DATA_W)'($urandom);
            chk({tag, "_busy"}, 128'(busy), 128'(1));
            chk({tag, "_addr"}, 128'(drain_addr), 128'(beat % DEPTH));
            chk({tag, "_data"}, 128'(drain_data), 128'(exp_row(beat)));
            chk({tag, "_last"}, 128'(drain_last), 128'(beat == DEPTH - 1));
            if (drain_ready) beat++;
            tick();
            cyc++;
        end
        wr_en = '0;
        drain_ready = 1'b0;
        chk({tag, "_beats"}, 128'(beat), 128'(DEPTH));
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_valid_end"}, 128'(drain_valid), 128'(0));
        chk({tag, "_busy_end"}, 128'(busy), 128'(0));
        tick();
        chk({tag, "_done_drop"}, 128'(done), 128'(0));
    endtask

    initial begin
        int cyc;
        int beat;
        nrst = 1'b0; wr_en = '0; acc_mode = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; clr_start = 1'b0; drain_start = 1'b0; drain_ready = 1'b0;
        tick(); tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(done), 0);
        chk("rst_dvalid", 128'(drain_valid), 0);
        chk("rst_daddr", 128'(drain_addr), 0);
        chk("rst_ddata", 128'(drain_data), 0);
        chk("rst_dlast", 128'(drain_last), 0);
        nrst = 1'b1;

        do_clear("clear1");
        sweep("zero_sweep");

        // Overwrite with same-cycle read returning the old value.
        for (int c = 0; c < CH; c++) begin
            wr_addr[c]    = ADDR_W'(c == 0 ? 1 : c + 4);
            wr_data[c]    = DATA_W'(c == 0 ? 1 : c + 4);
            rd_addr[0][c] = wr_addr[c];
        end
        wr_en = '1; acc_mode = 1'b0;
        idle_step("ovw_same_cycle");
        chk("ovw_old_value", 128'(rd_data[0]), 0);
        wr_en = '0;
        idle_step("ovw_next");
        chk("ovw_new_value", 128'(rd_data[0]), 128'({8'd7, 8'd6, 8'd5, 8'd1}));

        // Saturating accumulate.
        do_clear("clear2");
        wr_en = 4'b0100; acc_mode = 1'b0; wr_addr[2] = 5'd3; wr_data[2] = 8'd100;
        idle_step("acc_s1");
        wr_en = 4'b0110; acc_mode = 1'b1; wr_addr[1] = 5'd0; wr_data[1] = 8'h80;
        idle_step("acc_s2");
        wr_en = 4'b0011; wr_addr[0] = 5'd4; wr_data[0] = 8'd3;
        idle_step("acc_s3");
        wr_en = 4'b0001; wr_data[0] = 8'hFB;
        idle_step("acc_s4");
        wr_en = '0; acc_mode = 1'b0;
        rd_addr[0][0] = 5'd4; rd_addr[0][1] = 5'd0; rd_addr[0][2] = 5'd3;
        idle_step("acc_load");
        idle_step("acc_read");
        chk("acc_back_to_back", 128'(rd_data[0][0]), 128'(8'hFE));
        chk("acc_sat_neg", 128'(rd_data[0][1]), 128'(8'h80));
        chk("acc_sat_pos", 128'(rd_data[0][2]), 128'(8'h7F));

        // Drain with backpressure on a 4k+c pattern.
        wr_en = '1; acc_mode = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < CH; c++) begin
                wr_addr[c] = ADDR_W'(k);
                wr_data[c] = DATA_W'(4 * k + c);
            end
            idle_step("fill");
        end
        wr_en = '0;
        run_drain(0, "drain_bp");
        sweep("post_drain_sweep");

        // clr+drain together -> clear only; drain_start during clear and DONE ignored.
        clr_start = 1'b1; drain_start = 1'b1;
        tick();
        clr_start = 1'b0; drain_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            drain_start = (cyc == 5);
            chk("prio_no_drain", 128'(drain_valid), 0);
            cyc++;
            tick();
        end
        chk("prio_clear_len", 128'(cyc), 128'(DEPTH));
        chk("prio_done", 128'(done), 1);
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < DEPTH; k++) model[c][k] = 0;
            wr_addr[c] = '0;
            wr_data[c] = 8'd55;
        end
        wr_en = '1; acc_mode = 1'b0; drain_start = 1'b1;
        tick();
        wr_en = '0; drain_start = 1'b0;
        chk("done_start_busy", 128'(busy), 0);
        chk("done_start_valid", 128'(drain_valid), 0);
        tick();
        chk("done_start_busy2", 128'(busy), 0);
        chk("done_start_valid2", 128'(drain_valid), 0);
        sweep("prio_sweep");

        // Random writes/reads.
        for (int i = 0; i < 300; i++) begin
            wr_en    = CH'($urandom);
            acc_mode = 1'($urandom);
            wr_addr  = (CH*ADDR_W)'($urandom);
            for (int c = 0; c < CH; c++)
                wr_data[c] = ($urandom_range(0, 3) == 0) ? 8'h7F : DATA_W'($urandom);
            rd_addr  = (NRD*CH*ADDR_W)'({$urandom, $urandom, $urandom});
            idle_step("rand");
        end
        wr_en = '0;

        // Reset at drain beat 10, then a fresh drain restarts at 0.
        drain_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        beat = 0;
        while (drain_valid && drain_addr != 5'd10 && beat < 100) begin
            chk("pre_rst_addr", 128'(drain_addr), 128'(beat));
            beat++;
            tick();
        end
        chk("pre_rst_at10", 128'(drain_addr), 128'(10));
        nrst = 1'b0;
        tick();
        chk("mid_rst_valid", 128'(drain_valid), 0);
        chk("mid_rst_addr", 128'(drain_addr), 0);
        chk("mid_rst_data", 128'(drain_data), 0);
        chk("mid_rst_last", 128'(drain_last), 0);
        chk("mid_rst_busy", 128'(busy), 0);
        chk("mid_rst_rd", rd_data, 0);
        nrst = 1'b1; drain_ready = 1'b0;
        tick();
        chk("mid_rst_no_done", 128'(done), 0);
        tick();
        chk("mid_rst_no_done2", 128'(done), 0);
        run_drain(1, "drain_restart");
        sweep("final_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_output_buffer.md
Name: accum_output_buffer

Overview:
Parametrised, multi-channel output buffer for the CNN accelerator datapath. Each channel holds a DEPTH-entry bank that PE columns write per channel, either as an overwrite or as a saturating partial-sum accumulate. The buffer has NRD independent registered read ports. A clear engine zeroes all banks and a drain engine streams all banks out over a valid/ready interface to the writeback path.

Parameters:
DATA_W, 8, signed element width
CH, 4, number of channels (banks)
DEPTH, 32, entries per bank (power of two, >=2)
NRD, 4, number of read ports
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  synchronous active-low reset
wr_en  in  [CH]  per-channel write strobe
acc_mode  in  1  0 = overwrite, 1 = accumulate (global for all channels)
wr_addr  in  [CH][ADDR_W]  per-channel write address
wr_data  in  [CH][DATA_W]  per-channel write data, signed
rd_addr  in  [NRD][CH][ADDR_W]  read address per port per channel
rd_data  out  [NRD][CH][DATA_W]  registered read data
clr_start  in  1  pulse: zero every entry of every bank
drain_start  in  1  pulse: stream entries 0..DEPTH-1 of all channels
busy  out  1  high while clearing or draining
drain_valid  out  1  drain beat valid
drain_ready  in  1  downstream accept
drain_data  out  [CH][DATA_W]  one entry from every channel at drain_addr
drain_addr  out  ADDR_W  entry index of the current beat
drain_last  out  1  high with the beat at address DEPTH-1
done  out  1  one-cycle pulse when a clear or drain finishes

Behaviour:
- Reset (nrst=0 at a clock edge):
  - FSM goes to IDLE.
  - rd_data, drain_data, drain_addr, drain_valid, drain_last, busy and done are all 0.
  - Bank contents are not reset; software issues clr_start after reset.
  - Reset mid-clear or mid-drain aborts immediately, and done does not pulse.
- Writes (IDLE only), per channel c, when wr_en[c]=1:
  - acc_mode=0: mem[c][wr_addr[c]] <= wr_data[c].
  - acc_mode=1: mem[c][wr_addr[c]] <= sat(mem[c][wr_addr[c]] + wr_data[c]).
  - The sum is formed at DATA_W+1 bits, then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Accumulate takes one cycle. Back-to-back accumulates to the same address in consecutive cycles must each see the previously written value.
- Writes while busy=1 are dropped silently.
- Reads:
  - rd_data[p][c] <= mem[c][rd_addr[p][c]] every cycle: one-cycle latency, always enabled.
  - Reads are served in every state, including during clear and drain.
  - Read and write to the same address in the same cycle returns the old (pre-write) value. The new value is visible on the next read.
- FSM states: IDLE, CLEAR, DRAIN, DONE.
  - IDLE -> CLEAR on clr_start. IDLE -> DRAIN on drain_start.
  - If both pulse in the same cycle, CLEAR wins and drain_start is ignored.
  - Start pulses outside IDLE are ignored.
- CLEAR:
  - Internal counter k runs from 0 to DEPTH-1, one entry per cycle.
  - Each cycle writes mem[c][k] <= 0 for all c.
  - After k=DEPTH-1 go to DONE. Total DEPTH cycles with busy=1.
- DRAIN:
  - Counter k starts at 0.
  - drain_valid=1, drain_addr=k, drain_data[c]=mem[c][k]. drain_data, drain_addr and drain_last are registered outputs.
  - First beat is valid on the cycle after drain_start.
  - A beat completes when drain_valid && drain_ready. k then increments, and the next beat is presented on the following cycle.
  - While drain_valid && !drain_ready, drain_data, drain_addr and drain_last hold stable.
  - drain_last=1 only when k=DEPTH-1.
  - The handshake on the last beat goes to DONE, with drain_valid=0 in that next cycle.
  - No beat is duplicated or skipped across stalls of any length.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
  - Writes and starts presented in the DONE cycle are ignored.
  - busy is high throughout CLEAR and DRAIN and low in IDLE and DONE.
- Address wrap: the k counter never exceeds DEPTH-1. The FSM exits on the last index, so k never wraps within an operation.

Test Plan:
- Reset, then clr_start: busy=1 for exactly 32 cycles, then done=1 for one cycle. Afterwards, reading every address on all 4 ports returns 0.
- Overwrite: ch0..ch3 write 1,5,6,7 at addrs 1,5,6,7. Next cycle, rd_addr port0={1,5,6,7} returns {1,5,6,7} one cycle later. Same-cycle read of the address being written returns the old value 0.
- Accumulate saturation (DATA_W=8): clear, write 100 to ch2 addr 3, then accumulate +100 -> 127. Accumulate -128 twice at ch1 addr 0 -> -128. Accumulate 3 then -5 on consecutive cycles at ch0 addr 4 -> -2.
- Drain with backpressure: fill mem[c][k]=4k+c, drain_start, toggle drain_ready 1,0,0,1,...
  - Exactly 32 beats are accepted, with drain_addr 0..31 in order and drain_data {4k,4k+1,4k+2,4k+3}.
  - Data is held stable during stalls. drain_last is high only at addr 31, then done pulses.
- Blocking and priority:
  - clr_start and drain_start in the same cycle -> CLEAR only.
  - wr_en during drain -> memory unchanged.
  - drain_start during CLEAR -> ignored.
- Reset mid-drain at beat 10 -> outputs 0 next cycle, no done pulse. A fresh drain_start afterwards restarts at drain_addr 0.
